wb_write_port_arbiter: RTL and testbench
========================================

Name: wb_write_port_arbiter

Overview:
- Sole writer of the register-file write port (RegWrite / write_register / write_data).
- Merges two result sources: the in-order MEM/WB pipeline result and results returned by long-latency units (multiply/divide, cache-miss loads).
- The pipeline source always wins the port. Long-latency results wait in a small queue and drain on free cycles.
- A younger pipeline write to the same register squashes an older queued write.

Parameters:
- DATA_W, 32, register data width.
- REG_ADDR_W, 5, register index width.
- LQ_DEPTH, 2, long-latency queue entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  MEM/WB result present this cycle; cannot be stalled.
- pipe_reg  in  REG_ADDR_W  destination register of pipeline result.
- pipe_data  in  DATA_W  pipeline result value.
- lng_valid  in  1  long-latency result offered.
- lng_ready  out  1  arbiter accepts lng result this cycle.
- lng_reg  in  REG_ADDR_W  destination register of long-latency result.
- lng_data  in  DATA_W  long-latency result value.
- RegWrite  out  1  register-file write enable (registered).
- write_register  out  REG_ADDR_W  register-file write index (registered).
- write_data  out  DATA_W  register-file write data (registered).
- lq_count  out  $clog2(LQ_DEPTH)+1  occupied queue slots.
- busy  out  1  queue non-empty or RegWrite high.

Behaviour:
- Reset (async, while rst_n=0):
  - RegWrite=0, write_register=0, write_data=0.
  - Queue empty, lq_count=0, lng_ready=0.
- After reset, lng_ready = (lq_count < LQ_DEPTH), combinational from registered count.
  - A full queue deasserts ready even if a dequeue happens in the same cycle.
- Register $0 handling: a pipe or lng result with reg=0 produces no write and uses no port cycle. An lng result to $0 is accepted (handshake completes) and discarded without enqueue.
- Per-cycle port selection (priority order):
  1. pipe_valid && pipe_reg!=0 → next-cycle RegWrite=1, write_register=pipe_reg, write_data=pipe_data.
  2. Otherwise, if the queue head is valid → write the head and pop it.
  3. Otherwise → RegWrite=0; write_register and write_data hold their previous values.
- Latency:
  - Pipeline result at cycle N → write asserted during cycle N+1.
  - lng handshake at cycle N → entry visible cycle N+1 → earliest write cycle N+2.
- Squash: when a pipe write to R is selected, every queued entry with reg==R has its valid bit cleared in the same cycle. This includes an entry enqueued that same cycle.
- Invalid (squashed) head: popped without a write. This pop may occur in the same cycle as a pipe write. Only one pop per cycle.
- Queue ordering: FIFO with wrap-around pointers. Simultaneous enqueue and pop is allowed when not full. lq_count counts slots regardless of valid bit.
- RegWrite is a single-cycle pulse per write. Back-to-back writes keep it high.
- rst_n asserted mid-drain: queued entries are lost, outputs clear immediately, no partial write.

Optional Feature:
- WB_BYPASS_EN:
  - Defined: when the queue is empty, no pipe write is selected and lng_valid && lng_reg!=0, the lng result goes straight to the port; write at N+1, no enqueue. lng_ready is unchanged.
  - Undefined: all lng results pass through the queue, latency N+2.

Decomposition:
- Package wb_pkg:
  - DATA_W, REG_ADDR_W, ZERO_REG=0.
  - Typedef wb_entry_t {valid, reg[REG_ADDR_W], data[DATA_W]}.
- Sub-module wb_lq_fifo: LQ_DEPTH entries of wb_entry_t, push/pop, per-entry squash compare against a squash_reg/squash_en input, count output.

Test Plan:
- Reset release, idle: RegWrite=0, lng_ready=1, lq_count=0, busy=0.
- pipe_valid, reg 8, data 0x0000_1234 at N → RegWrite=1, write_register=8, write_data=0x1234 at N+1 only.
- lng reg 9, data 0xDEAD_BEEF accepted at N with pipe idle → write at N+2 (N+1 with WB_BYPASS_EN). lq_count 1 then 0.
- Two lng results (reg 3, reg 4) with pipe_valid high for 4 cycles → lng_ready=0 after the 2nd; queue holds; writes of 3 then 4 follow once pipe goes idle.
- lng reg 5 = 0x11 queued, then pipe reg 5 = 0x22 → only 0x22 written to reg 5; squashed entry pops with no write.
- pipe reg 0 and lng reg 0 → no RegWrite pulse; lng handshake completes; lq_count stays 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the queue-entry type for the register-file write-port arbiter.
package wb_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] reg_idx;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // A result only costs a port cycle when it targets a real register.
    function automatic logic is_write(input logic valid, input logic [REG_ADDR_W-1:0] reg_idx);
        return valid && (reg_idx != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_lq_fifo.sv
// Long-latency result queue: wrap-around FIFO whose entries can be squashed
// in place by a younger pipeline write to the same register.
module wb_lq_fifo
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  wb_entry_t                   i_push_entry,
    input  logic                        i_pop,
    input  logic                        i_squash_en,
    input  logic [REG_ADDR_W-1:0]       i_squash_reg,
    output wb_entry_t                   o_head,
    output logic [$clog2(LQ_DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [LQ_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        w_push_entry;

    // An entry arriving in the same cycle as a matching pipe write is born dead.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_push_entry = i_push_entry;
        if (i_squash_en && (i_push_entry.reg_idx == i_squash_reg)) begin
            w_push_entry.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry array has no reset; r_count alone marks which slots are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (i_squash_en && (r_mem[i].reg_idx == i_squash_reg)) begin
                r_mem[i].valid <= 1'b0;
            end
        end
        if (i_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/wb_write_port_arbiter.sv
// Sole driver of the register-file write port: pipeline results win, long-latency
// results queue and drain on free cycles. Optional macro: WB_BYPASS_EN.
module wb_write_port_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_valid,
    input  logic [REG_ADDR_W-1:0]       pipe_reg,
    input  logic [DATA_W-1:0]           pipe_data,
    input  logic                        lng_valid,
    output logic                        lng_ready,
    input  logic [REG_ADDR_W-1:0]       lng_reg,
    input  logic [DATA_W-1:0]           lng_data,
    output logic                        RegWrite,
    output logic [REG_ADDR_W-1:0]       write_register,
    output logic [DATA_W-1:0]           write_data,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        busy
);

    localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_register;
    logic [DATA_W-1:0]     r_write_data;

    logic                  w_pipe_sel;
    logic                  w_lng_acc;
    logic                  w_lng_live;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_live;
    logic [CNT_W-1:0]      w_count;
    wb_entry_t             w_head;
    wb_entry_t             w_push_entry;
    logic                  w_wr_en;
    logic [REG_ADDR_W-1:0] w_wr_reg;
    logic [DATA_W-1:0]     w_wr_data;

    // Ready looks only at the registered count; a same-cycle pop does not reopen a full queue.
    assign lng_ready  = rst_n && (w_count < DEPTH_C);
    assign w_lng_acc  = lng_valid && lng_ready;
    assign w_lng_live = w_lng_acc && (lng_reg != ZERO_REG);
    assign w_pipe_sel = is_write(pipe_valid, pipe_reg);
    assign w_head_live = (w_count != '0);

`ifdef WB_BYPASS_EN
    assign w_bypass = w_lng_live && !w_pipe_sel && !w_head_live;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push       = w_lng_live && !w_bypass;
    assign w_push_entry = '{valid: 1'b1, reg_idx: lng_reg, data: lng_data};

    // A squashed head leaves even under a pipe write; a live head waits for a free port.
    assign w_pop = w_head_live && (!w_head.valid || !w_pipe_sel);

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_reg  = r_write_register;
        w_wr_data = r_write_data;
        if (w_pipe_sel) begin
            w_wr_en   = 1'b1;
            w_wr_reg  = pipe_reg;
            w_wr_data = pipe_data;
        end else if (w_head_live && w_head.valid) begin
            w_wr_en   = 1'b1;
            w_wr_reg  = w_head.reg_idx;
            w_wr_data = w_head.data;
        end else if (w_bypass) begin
            w_wr_en   = 1'b1;
            w_wr_reg  = lng_reg;
            w_wr_data = lng_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
        end else begin
            r_reg_write      <= w_wr_en;
            r_write_register <= w_wr_reg;
            r_write_data     <= w_wr_data;
        end
    end

    wb_lq_fifo #(
        .LQ_DEPTH (LQ_DEPTH)
    ) u_lq_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_squash_en  (w_pipe_sel),
        .i_squash_reg (pipe_reg),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign RegWrite       = r_reg_write;
    assign write_register = r_write_register;
    assign write_data     = r_write_data;
    assign lq_count       = w_count;
    assign busy           = w_head_live || r_reg_write;

endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// Scoreboard bench for wb_write_port_arbiter: a queue-level reference model predicts
// port writes and queue status; a negedge monitor compares them against the DUT.
module tb_wb_write_port_arbiter;
    import wb_pkg::*;

    localparam int LQ_DEPTH = 2;
    localparam int CNT_W    = $clog2(LQ_DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  pipe_valid;
    logic [REG_ADDR_W-1:0] pipe_reg;
    logic [DATA_W-1:0]     pipe_data;
    logic                  lng_valid;
    logic                  lng_ready;
    logic [REG_ADDR_W-1:0] lng_reg;
    logic [DATA_W-1:0]     lng_data;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] write_register;
    logic [DATA_W-1:0]     write_data;
    logic [CNT_W-1:0]      lq_count;
    logic                  busy;

    wb_write_port_arbiter #(
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_valid     (pipe_valid),
        .pipe_reg       (pipe_reg),
        .pipe_data      (pipe_data),
        .lng_valid      (lng_valid),
        .lng_ready      (lng_ready),
        .lng_reg        (lng_reg),
        .lng_data       (lng_data),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .lq_count       (lq_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    cyc;
        logic [REG_ADDR_W-1:0] r;
        logic [DATA_W-1:0]     d;
    } exp_wr_t;

    typedef struct {
        int cyc;
        int cnt;
        bit rdy;
        bit bsy;
    } exp_sts_t;

    typedef struct {
        bit                    v;
        logic [REG_ADDR_W-1:0] r;
        logic [DATA_W-1:0]     d;
    } mdl_ent_t;

    exp_wr_t  exp_q[$];
    exp_sts_t sts_q[$];
    mdl_ent_t mq[$];

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: applies one clock's worth of the arbitration rules to the
    // queue image and records what the DUT must show after the coming edge.
    task automatic model_step();
        bit pipe_wr;
        bit acc;
        bit byp;
        bit popped;
        bit wrote;
        int n;
        n       = cyc + 1;
        pipe_wr = pipe_valid && (pipe_reg != 0);
        acc     = lng_valid && (mq.size() < LQ_DEPTH);
        byp     = 1'b0;
        popped  = 1'b0;
        wrote   = 1'b0;
`ifdef WB_BYPASS_EN
        byp = !pipe_wr && acc && (lng_reg != 0) && (mq.size() == 0);
`endif
        if (pipe_wr) begin
            exp_q.push_back('{n, pipe_reg, pipe_data});
            wrote = 1'b1;
        end else if (mq.size() > 0 && mq[0].v) begin
            exp_q.push_back('{n, mq[0].r, mq[0].d});
            void'(mq.pop_front());
            popped = 1'b1;
            wrote  = 1'b1;
        end else if (byp) begin
            exp_q.push_back('{n, lng_reg, lng_data});
            wrote = 1'b1;
        end
        if (!popped && mq.size() > 0 && !mq[0].v) begin
            void'(mq.pop_front());
        end
        if (pipe_wr) begin
            foreach (mq[i]) begin
                if (mq[i].r == pipe_reg) mq[i].v = 1'b0;
            end
        end
        if (acc && (lng_reg != 0) && !byp) begin
            mq.push_back('{!(pipe_wr && (lng_reg == pipe_reg)), lng_reg, lng_data});
        end
        sts_q.push_back('{n, mq.size(), mq.size() < LQ_DEPTH, (mq.size() != 0) || wrote});
    endtask

    task automatic drive(input bit pv, input logic [REG_ADDR_W-1:0] pr, input logic [DATA_W-1:0] pd,
                         input bit lv, input logic [REG_ADDR_W-1:0] lr, input logic [DATA_W-1:0] ld);
        @(negedge clk);
        pipe_valid = pv;
        pipe_reg   = pr;
        pipe_data  = pd;
        lng_valid  = lv;
        lng_reg    = lr;
        lng_data   = ld;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_we;
            exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("RegWrite", 64'(RegWrite), 64'(exp_we));
            if (exp_we) begin
                if (RegWrite) begin
                    check("write_register", 64'(write_register), 64'(exp_q[0].r));
                    check("write_data", 64'(write_data), 64'(exp_q[0].d));
                end
                void'(exp_q.pop_front());
            end
            if (sts_q.size() > 0 && sts_q[0].cyc == cyc) begin
                check("lq_count", 64'(lq_count), 64'(sts_q[0].cnt));
                check("lng_ready", 64'(lng_ready), 64'(sts_q[0].rdy));
                check("busy", 64'(busy), 64'(sts_q[0].bsy));
                void'(sts_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_RegWrite"}, 64'(RegWrite), 64'(0));
        check({tag, "_write_register"}, 64'(write_register), 64'(0));
        check({tag, "_write_data"}, 64'(write_data), 64'(0));
        check({tag, "_lq_count"}, 64'(lq_count), 64'(0));
        check({tag, "_lng_ready"}, 64'(lng_ready), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        pipe_valid = 1'b0;
        pipe_reg   = '0;
        pipe_data  = '0;
        lng_valid  = 1'b0;
        lng_reg    = '0;
        lng_data   = '0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(3);

        // Pipeline write to reg 8.
        drive(1'b1, 5'd8, 32'h0000_1234, 1'b0, '0, '0);
        idle(3);

        // Long-latency write through the queue (or bypass).
        drive(1'b0, '0, '0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        idle(4);

        // Queue fills behind a busy pipe, then drains in order.
        drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h0300);
        drive(1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h0400);
        drive(1'b1, 5'd12, 32'hA2, 1'b1, 5'd6, 32'h0600);
        drive(1'b1, 5'd13, 32'hA3, 1'b0, '0, '0);
        idle(5);

        // Squash: queued reg 5 = 0x11 is overtaken by pipe reg 5 = 0x22.
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'h11);
        drive(1'b1, 5'd5, 32'h22, 1'b0, '0, '0);
        idle(4);

        // Same-cycle squash of an entry being enqueued.
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h70);
        idle(4);

        // Register $0 from both sources.
        drive(1'b1, 5'd0, 32'hFFFF_0000, 1'b1, 5'd0, 32'h0000_FFFF);
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1);
        idle(3);

        // Randomized traffic with a narrow register range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 1) == 1), REG_ADDR_W'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 4), REG_ADDR_W'($urandom_range(0, 7)), $urandom);
        end
        idle(6);

        // Reset asserted while the queue is draining.
        drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121);
        drive(1'b1, 5'd22, 32'h2222, 1'b1, 5'd23, 32'h2323);
        idle(1);
        @(posedge clk);
        #2;
        check("pre_rst_lq_count", 64'(lq_count), 64'(1));
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        sts_q.delete();
        mq.delete();
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);
        drive(1'b1, 5'd14, 32'h0E0E, 1'b1, 5'd15, 32'h0F0F);
        idle(8);

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
